muldiv_hilo_writer: RTL and testbench
=====================================

# muldiv_hilo_writer

Multiply/divide unit that produces the HI/LO write traffic for the MIPS core. It sits in the execute stage and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO. For each accepted op it emits exactly one HI/LO write strobe, carrying both halves. Division is iterative and stalls the pipeline through `busy_o`; all other ops complete without a stall.

## Interface
- No parameters; data width is 32 bits (`` `DATA_BUS``).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  issue strobe; sampled on the rising edge.
- `op_i`  in  3  operation code:
  - 3'b001 MULT, 3'b010 MULTU, 3'b011 DIV, 3'b100 DIVU, 3'b101 MTHI, 3'b110 MTLO.
  - Any other code: start is ignored.
- `operand_a_i`  in  32  rs value (dividend, multiplicand, or MTHI/MTLO source).
- `operand_b_i`  in  32  rt value (divisor or multiplier).
- `hi_cur_i`, `lo_cur_i`  in  32 each  current forwarded HI/LO; supplies the unchanged half for MTHI/MTLO.
- `flush_i`  in  1  cancels any accepted or in-flight op.
- `busy_o`  out  1  stall request to the pipeline.
- `hilo_write_en_o`  out  1  one-cycle HI/LO write strobe.
- `hi_o`, `lo_o`  out  32 each  write data; valid only while `hilo_write_en_o`=1.

## Operation
- States: IDLE, DIV, DONE. Reset sets the state to IDLE and sets every output and internal register to 0.
- An op is accepted when `start_i`=1, `op_i` is valid, `flush_i`=0 and the state is IDLE or DONE. Starts arriving in DIV are ignored.
- MULT/MULTU:
  - 64-bit product captured on the accept edge; state goes to DONE.
  - `hi_o` = product[63:32], `lo_o` = product[31:0].
  - MULT is signed; MULTU is unsigned.
- MTHI: `hi_o` = operand_a, `lo_o` = `lo_cur_i`, both captured on the accept edge; state goes to DONE.
- MTLO: `lo_o` = operand_a, `hi_o` = `hi_cur_i`, both captured on the accept edge; state goes to DONE.
- DIV/DIVU:
  - Magnitudes are latched and the iteration counter is cleared; state goes to DIV.
  - Restoring division, one quotient bit per cycle, 32 iterations; then state goes to DONE.
  - `lo_o` = quotient, `hi_o` = remainder.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign. Example: -7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
  - Divisor 0, both DIV and DIVU: lo=0xFFFFFFFF, hi=operand_a. Result forced on the transition into DONE.
- DONE:
  - `hilo_write_en_o`=1 for exactly that cycle.
  - Next state is IDLE, or a new op if one is accepted in the same cycle (back-to-back issue).
- Flush:
  - A rising edge with `flush_i`=1 forces IDLE and suppresses any pending write.
  - Flush has priority over start.
  - A DONE cycle coinciding with `flush_i` still writes, because its op has already committed.
- `busy_o` = !flush_i & ((IDLE|DONE) & start_i & op∈{DIV,DIVU} | state==DIV).

## Timing
- Cycle 0 is the accept cycle.
- MULT/MULTU/MTHI/MTLO: write strobe in cycle 1; `busy_o` stays 0 throughout.
- DIV/DIVU:
  - `busy_o`=1 in cycles 0..32.
  - DIV state occupies cycles 1..32.
  - Write strobe in cycle 33, with `busy_o`=0 in that cycle.
- `hi_o`/`lo_o` are registered and hold their last value outside the strobe.
- Asserting `rst` mid-division drops the op immediately; no strobe is produced.

## Configuration
- `MULDIV_DIV_ZERO_FAST_EN` defined:
  - A division with divisor 0 goes from accept straight to DONE; strobe in cycle 1.
  - `busy_o` is never asserted for that division.
- Macro undefined: divisor 0 runs the full 32 iterations, strobe in cycle 33.
- Result values are identical in both builds.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 → cycle 1: strobe, hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → `busy_o` high in cycles 0..32; cycle 33: strobe, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5; strobe in cycle 33 without the macro, cycle 1 with it.
- MTHI a=0x12345678 with lo_cur=0xAAAA5555 → cycle 1: hi=0x12345678, lo=0xAAAA5555. Issue MTLO in that same DONE cycle → strobe again in cycle 2.
- DIVU started, then `flush_i` in cycle 10 → no strobe, `busy_o` low from cycle 10. A start attempted during DIV is ignored.
- `rst` asserted mid-division in cycle 5 → all outputs 0 immediately. A MULT after release produces a normal strobe.

Source files
------------

// File: rtl/muldiv_hilo_writer.sv
// muldiv_hilo_writer: MIPS HI/LO write generator for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Define MULDIV_DIV_ZERO_FAST_EN to complete divide-by-zero without iterating.
module muldiv_hilo_writer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic [31:0] hi_cur_i,
   input  logic [31:0] lo_cur_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        hilo_write_en_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic        is_mul, is_div, sdiv, valid_op, accept, ok;
   logic [31:0] abs_a, abs_b, rem_n, quo_n, q_fix, r_fix;
   logic [32:0] rem_sh, diff;
   logic [63:0] ext_a, ext_b, prod;

   assign is_mul   = op_i == 3'b001 || op_i == 3'b010;
   assign is_div   = op_i == 3'b011 || op_i == 3'b100;
   assign sdiv     = op_i == 3'b011;
   assign valid_op = op_i != 3'b000 && op_i != 3'b111;
   assign accept   = start_i && valid_op && !flush_i && state_q != DIV;
   assign abs_a    = sdiv && operand_a_i[31] ? -operand_a_i : operand_a_i;
   assign abs_b    = sdiv && operand_b_i[31] ? -operand_b_i : operand_b_i;
   // Low 64 bits of an unsigned product of sign-extended operands equal the signed product
   assign ext_a    = {{32{op_i == 3'b001 && operand_a_i[31]}}, operand_a_i};
   assign ext_b    = {{32{op_i == 3'b001 && operand_b_i[31]}}, operand_b_i};
   assign prod     = ext_a * ext_b;
   assign rem_sh   = {rem_q, quo_q[31]};
   assign diff     = rem_sh - {1'b0, dvs_q};
   assign ok       = !diff[32];
   assign rem_n    = ok ? diff[31:0] : rem_sh[31:0];
   assign quo_n    = {quo_q[30:0], ok};
   assign q_fix    = dz_q ? 32'hFFFF_FFFF : qneg_q ? -quo_n : quo_n;
   assign r_fix    = dz_q ? a_q : rneg_q ? -rem_n : rem_n;

`ifdef MULDIV_DIV_ZERO_FAST_EN
   assign busy_o = !flush_i && ((state_q != DIV && start_i && is_div && operand_b_i != 32'd0) || state_q == DIV);
`else
   assign busy_o = !flush_i && ((state_q != DIV && start_i && is_div) || state_q == DIV);
`endif
   assign hilo_write_en_o = state_q == DONE;
   assign hi_o = hi_q;
   assign lo_o = lo_q;

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      if (flush_i) begin
         state_d = IDLE;
      end else if (accept && is_div) begin
         rem_d   = '0;
         quo_d   = abs_a;
         dvs_d   = abs_b;
         a_d     = operand_a_i;
         cnt_d   = '0;
         qneg_d  = sdiv && (operand_a_i[31] ^ operand_b_i[31]);
         rneg_d  = sdiv && operand_a_i[31];
         dz_d    = operand_b_i == 32'd0;
         state_d = DIV;
`ifdef MULDIV_DIV_ZERO_FAST_EN
         if (operand_b_i == 32'd0) begin
            hi_d    = operand_a_i;
            lo_d    = 32'hFFFF_FFFF;
            state_d = DONE;
         end
`endif
      end else if (accept) begin
         hi_d    = is_mul ? prod[63:32] : op_i == 3'b101 ? operand_a_i : hi_cur_i;
         lo_d    = is_mul ? prod[31:0] : op_i == 3'b110 ? operand_a_i : lo_cur_i;
         state_d = DONE;
      end else if (state_q == DIV) begin
         rem_d = rem_n;
         quo_d = quo_n;
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            hi_d    = r_fix;
            lo_d    = q_fix;
            state_d = DONE;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end
endmodule

// File: tb/tb_muldiv_hilo_writer.sv
// tb_muldiv_hilo_writer: randomized and directed bench for muldiv_hilo_writer.
// Reference model schedules each accepted op's write by cycle number.
module tb_muldiv_hilo_writer;
   logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, flush_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] operand_a_i = '0, operand_b_i = '0, hi_cur_i = '0, lo_cur_i = '0;
   logic        busy_o, hilo_write_en_o;
   logic [31:0] hi_o, lo_o;

   muldiv_hilo_writer dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .hi_cur_i(hi_cur_i), .lo_cur_i(lo_cur_i), .flush_i(flush_i),
      .busy_o(busy_o), .hilo_write_en_o(hilo_write_en_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0, cyc = 0, pend_due = 0;
   bit          pend_v = 0, pend_long = 0;
   logic [31:0] pend_hi = '0, pend_lo = '0, last_hi = '0, last_lo = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] exp_res(input logic [2:0] op, input logic [31:0] a, b, hc, lc);
      int sa, sb;
      longint p;
      sa = a;
      sb = b;
      if (op == 3'd1) begin
         p = longint'(sa) * longint'(sb);
         return 64'(p);
      end
      if (op == 3'd2) return {32'd0, a} * {32'd0, b};
      if ((op == 3'd3 || op == 3'd4) && b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
      if (op == 3'd3) return {32'(sa % sb), 32'(sa / sb)};
      if (op == 3'd4) return {a % b, a / b};
      if (op == 3'd5) return {a, lc};
      if (op == 3'd6) return {hc, a};
      return '0;
   endfunction

   function automatic bit long_div(input logic [2:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV_ZERO_FAST_EN
      return (op == 3'd3 || op == 3'd4) && b != 32'd0;
`else
      return op == 3'd3 || op == 3'd4;
`endif
   endfunction

   // One cycle: drive, compare against the model at the falling edge, advance the model
   task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a, b, hc, lc, input logic fl);
      bit in_div, ew, acc;
      logic [63:0] r;
      start_i = s; op_i = op; operand_a_i = a; operand_b_i = b;
      hi_cur_i = hc; lo_cur_i = lc; flush_i = fl;
      ew     = pend_v && pend_due == cyc;
      in_div = pend_v && pend_long && cyc < pend_due;
      acc    = s && op >= 3'd1 && op <= 3'd6 && !fl && !in_div;
      @(negedge clk);
      chk("we", 32'(hilo_write_en_o), 32'(ew));
      chk("busy", 32'(busy_o), 32'(!fl && (in_div || (s && long_div(op, b)))));
      chk("hi", hi_o, ew ? pend_hi : last_hi);
      chk("lo", lo_o, ew ? pend_lo : last_lo);
      if (ew) begin
         last_hi = pend_hi;
         last_lo = pend_lo;
         pend_v  = 0;
      end
      if (fl) pend_v = 0;
      if (acc) begin
         r         = exp_res(op, a, b, hc, lc);
         pend_v    = 1;
         pend_long = long_div(op, b);
         pend_due  = cyc + (pend_long ? 33 : 1);
         pend_hi   = r[63:32];
         pend_lo   = r[31:0];
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      step(1'b0, 3'd0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      while (!hilo_write_en_o && n < 40) begin
         idle();
         n++;
      end
      chk("strobe_seen", 32'(hilo_write_en_o), 32'd1);
   endtask

   task automatic check_lit(input string name, input logic [31:0] hi, input logic [31:0] lo);
      chk({name, "_we"}, 32'(hilo_write_en_o), 32'd1);
      chk({name, "_hi"}, hi_o, hi);
      chk({name, "_lo"}, lo_o, lo);
   endtask

   int n;
   int div_lat, zero_lat;

   initial begin
`ifdef MULDIV_DIV_ZERO_FAST_EN
      zero_lat = 0;
`else
      zero_lat = 32;
`endif
      div_lat = 32;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_we", 32'(hilo_write_en_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);

      step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, '0, '0, 1'b0);
      check_lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      step(1'b1, 3'd2, 32'hFFFF_FFFE, 32'd3, '0, '0, 1'b0);
      check_lit("multu", 32'h0000_0002, 32'hFFFF_FFFA);

      step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, '0, '0, 1'b0);
      wait_strobe(n);
      chk("div_lat", n, div_lat);
      check_lit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      step(1'b1, 3'd4, 32'd100, 32'd7, '0, '0, 1'b0);
      wait_strobe(n);
      chk("divu_lat", n, div_lat);
      check_lit("divu", 32'd2, 32'd14);
      step(1'b1, 3'd3, 32'd5, 32'd0, '0, '0, 1'b0);
      wait_strobe(n);
      chk("div0_lat", n, zero_lat);
      check_lit("div0", 32'd5, 32'hFFFF_FFFF);
      step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, 1'b0);
      wait_strobe(n);
      check_lit("div_ovf", 32'd0, 32'h8000_0000);

      step(1'b1, 3'd5, 32'h1234_5678, '0, '0, 32'hAAAA_5555, 1'b0);
      check_lit("mthi", 32'h1234_5678, 32'hAAAA_5555);
      step(1'b1, 3'd6, 32'h55AA_00FF, '0, 32'hCAFE_F00D, '0, 1'b0);
      check_lit("mtlo", 32'hCAFE_F00D, 32'h55AA_00FF);
      idle();

      step(1'b1, 3'd4, 32'd1000, 32'd3, '0, '0, 1'b0);
      repeat (4) idle();
      step(1'b1, 3'd1, 32'd7, 32'd7, '0, '0, 1'b0);
      repeat (4) idle();
      step(1'b0, 3'd0, '0, '0, '0, '0, 1'b1);
      repeat (30) idle();

      step(1'b1, 3'd3, 32'd99, 32'd4, '0, '0, 1'b0);
      repeat (4) idle();
      rst = 1'b1;
      #1;
      chk("rst_mid_we", 32'(hilo_write_en_o), 32'd0);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      chk("rst_mid_hi", hi_o, 32'd0);
      chk("rst_mid_lo", lo_o, 32'd0);
      pend_v = 0; last_hi = '0; last_lo = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      cyc++;
      step(1'b1, 3'd1, 32'd6, 32'd7, '0, '0, 1'b0);
      wait_strobe(n);
      check_lit("mult_after_rst", 32'd0, 32'd42);

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
         b = ($urandom_range(0, 6) == 0) ? 32'd0 : ($urandom_range(0, 6) == 0) ? 32'hFFFF_FFFF : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         step(1'(($urandom_range(0, 2) != 0)), 3'($urandom_range(0, 7)), a, b,
              $urandom, $urandom, 1'(($urandom_range(0, 19) == 0)));
      end
      repeat (40) idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
